ncl_qadd_seq: RTL and testbench

- Synchronous sequencer for a ripple chain of DIGITS quaternary (1-of-4) NCL full-adder stages.
- Accepts binary operands on a valid/ready interface and encodes them to dual-rail carry-in and quad-rail operands.
- Drives the DATA wavefront, waits for completion, then drives the NULL wavefront and waits for null completion.
- Returns the decoded binary sum and carry on a valid/ready result interface, and times out if the asynchronous array stalls.

---
 rtl/ncl_qadd_pkg.sv | 33 +++
 rtl/ncl_sync_bus.sv | 28 ++
 rtl/ncl_qadd_seq.sv | 204 ++++++++++++++++++++
 tb/tb_ncl_qadd_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncl_qadd_pkg.sv
// Shared types and rail helpers for the quaternary NCL adder sequencer.
// Quad-rail digits are 1-of-4 codes; dual-rail carries use the DR_* rail indices.
package ncl_qadd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DATA_WAIT,
      NULL_WAIT,
      RESULT,
      ERROR
   } state_t;

   localparam int DR_ZERO = 0;
   localparam int DR_ONE  = 1;

   function automatic logic [3:0] q_enc(input logic [1:0] v);
      q_enc = 4'b0001 << v;
   endfunction

   function automatic logic [1:0] q_dec(input logic [3:0] r);
      case (r)
         4'b0010: q_dec = 2'd1;
         4'b0100: q_dec = 2'd2;
         4'b1000: q_dec = 2'd3;
         default: q_dec = 2'd0;
      endcase
   endfunction

   function automatic logic q_onehot(input logic [3:0] r);
      q_onehot = (r != 4'b0000) && ((r & (r - 4'd1)) == 4'b0000);
   endfunction

endpackage

// File: rtl/ncl_sync_bus.sv
// Multi-flop synchroniser for a bundle of monotonic NCL return signals.
// Each bit is synchronised independently; rails only change in one direction per phase.
module ncl_sync_bus #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [STAGES-1:0][WIDTH-1:0] stage_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stage_reg <= '0;
      end else begin
         stage_reg[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign q = stage_reg[STAGES-1];

endmodule

// File: rtl/ncl_qadd_seq.sv
// Clocked sequencer driving DATA/NULL wavefronts through a quaternary NCL adder chain.
// Optional multi-rail fault detection is enabled by defining NCL_ONEHOT_CHECK_EN.
module ncl_qadd_seq
   import ncl_qadd_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  init,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [2*DIGITS-1:0]   a_bin,
   input  logic [2*DIGITS-1:0]   b_bin,
   input  logic                  cin,
   output logic [4*DIGITS-1:0]   aq,
   output logic [4*DIGITS-1:0]   bq,
   output logic [1:0]            carryin,
   output logic                  adder_init,
   input  logic [DIGITS-1:0]     ab_comp,
   input  logic [4*DIGITS-1:0]   sumq,
   input  logic [1:0]            carryout,
   output logic                  sum_comp,
   output logic                  carry_comp,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [2*DIGITS-1:0]   res_sum,
   output logic                  res_cout,
`ifdef NCL_ONEHOT_CHECK_EN
   output logic                  onehot_err,
`endif
   output logic                  err,
   input  logic                  err_clr
);

   localparam int W  = 2 * DIGITS;
   localparam int SW = DIGITS + 4 * DIGITS + 2;
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   state_t              state_reg;
   logic [TW-1:0]       timer_reg;
   logic [SYNC_STAGES:0] init_sr_reg;

   logic [SW-1:0]       sync_q;
   logic [DIGITS-1:0]   ab_comp_s;
   logic [4*DIGITS-1:0] sumq_s;
   logic [1:0]          carryout_s;

   logic [4*DIGITS-1:0] aq_enc, bq_enc;
   logic [1:0]          cin_enc;
   logic [W-1:0]        sum_dec;
   logic [DIGITS-1:0]   dig_onehot, dig_null;
   logic                dcomp, ncomp, in_wait, complete, timeout, onehot_fault, to_err;

   ncl_sync_bus #(.WIDTH(SW), .STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (init),
      .d   ({ab_comp, sumq, carryout}),
      .q   (sync_q)
   );

   assign ab_comp_s  = sync_q[SW-1 -: DIGITS];
   assign sumq_s     = sync_q[4*DIGITS+1 : 2];
   assign carryout_s = sync_q[1:0];

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_digit
         assign aq_enc[4*gi +: 4]  = q_enc(a_bin[2*gi +: 2]);
         assign bq_enc[4*gi +: 4]  = q_enc(b_bin[2*gi +: 2]);
         assign sum_dec[2*gi +: 2] = q_dec(sumq_s[4*gi +: 4]);
         assign dig_onehot[gi]     = q_onehot(sumq_s[4*gi +: 4]);
         assign dig_null[gi]       = (sumq_s[4*gi +: 4] == 4'b0000);
      end
   endgenerate

   always_comb begin
      cin_enc = 2'b00;
      cin_enc[cin ? DR_ONE : DR_ZERO] = 1'b1;
   end

   assign dcomp   = (&dig_onehot) && (carryout_s[DR_ONE] ^ carryout_s[DR_ZERO]) && (&ab_comp_s);
   assign ncomp   = (&dig_null) && (carryout_s == 2'b00) && (ab_comp_s == '0);
   assign timeout = (timer_reg == TW'(TIMEOUT_CYC - 1));

`ifdef NCL_ONEHOT_CHECK_EN
   logic [DIGITS-1:0] dig_multi;
   assign dig_multi = ~dig_onehot & ~dig_null;
   assign onehot_fault = in_wait && ((|dig_multi) || (&carryout_s));
`else
   assign onehot_fault = 1'b0;
`endif

   // A completion seen in the same cycle as the timeout wins; a rail fault beats both.
   always_comb begin
      in_wait  = (state_reg == DATA_WAIT) || (state_reg == NULL_WAIT);
      complete = (state_reg == DATA_WAIT) ? dcomp : ncomp;
      to_err   = in_wait && (onehot_fault || (!complete && timeout));
   end

   // Array init is held for SYNC_STAGES+1 edges so the synchronisers flush the old wavefront.
   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         init_sr_reg <= '1;
      end else begin
         init_sr_reg <= {init_sr_reg[SYNC_STAGES-1:0], 1'b0};
      end
   end

   assign adder_init = init_sr_reg[SYNC_STAGES];
   assign carry_comp = sum_comp;

   always_ff @(posedge clk or posedge init) begin
      if (init) begin
         state_reg  <= IDLE;
         timer_reg  <= '0;
         aq         <= '0;
         bq         <= '0;
         carryin    <= '0;
         sum_comp   <= 1'b0;
         in_ready   <= 1'b0;
         res_valid  <= 1'b0;
         res_sum    <= '0;
         res_cout   <= 1'b0;
         err        <= 1'b0;
`ifdef NCL_ONEHOT_CHECK_EN
         onehot_err <= 1'b0;
`endif
      end else if (to_err) begin
         state_reg  <= ERROR;
         timer_reg  <= '0;
         aq         <= '0;
         bq         <= '0;
         carryin    <= '0;
         sum_comp   <= 1'b1;
         in_ready   <= 1'b0;
         res_valid  <= 1'b0;
         err        <= 1'b1;
`ifdef NCL_ONEHOT_CHECK_EN
         onehot_err <= onehot_fault;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               timer_reg <= '0;
               if (in_valid && in_ready) begin
                  aq        <= aq_enc;
                  bq        <= bq_enc;
                  carryin   <= cin_enc;
                  in_ready  <= 1'b0;
                  state_reg <= DATA_WAIT;
               end else begin
                  in_ready  <= ~init_sr_reg[SYNC_STAGES-1];
               end
            end
            DATA_WAIT: begin
               if (dcomp) begin
                  res_sum   <= sum_dec;
                  res_cout  <= carryout_s[DR_ONE];
                  aq        <= '0;
                  bq        <= '0;
                  carryin   <= '0;
                  sum_comp  <= 1'b1;
                  timer_reg <= '0;
                  state_reg <= NULL_WAIT;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            NULL_WAIT: begin
               if (ncomp) begin
                  sum_comp  <= 1'b0;
                  res_valid <= 1'b1;
                  timer_reg <= '0;
                  state_reg <= RESULT;
               end else begin
                  timer_reg <= timer_reg + TW'(1);
               end
            end
            RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_reg <= IDLE;
               end
            end
            ERROR: begin
               if (err_clr && ncomp) begin
                  err        <= 1'b0;
`ifdef NCL_ONEHOT_CHECK_EN
                  onehot_err <= 1'b0;
`endif
                  sum_comp   <= 1'b0;
                  in_ready   <= 1'b1;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ncl_qadd_seq.sv
// Randomised bench for ncl_qadd_seq with a behavioural NCL array and a result scoreboard.
// Covers add/carry cases, backpressure, timeout, mid-op reset and the NCL_ONEHOT_CHECK_EN fault.
module tb_ncl_qadd_seq;

   localparam int DIGITS      = 4;
   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT_CYC = 1024;
   localparam int W           = 2 * DIGITS;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                init = 1'b0;
   logic                in_valid = 1'b0;
   logic                in_ready;
   logic [W-1:0]        a_bin = '0;
   logic [W-1:0]        b_bin = '0;
   logic                cin = 1'b0;
   logic [4*DIGITS-1:0] aq, bq;
   logic [1:0]          carryin;
   logic                adder_init;
   logic [DIGITS-1:0]   ab_comp = '0;
   logic [4*DIGITS-1:0] sumq = '0;
   logic [1:0]          carryout = '0;
   logic                sum_comp, carry_comp;
   logic                res_valid;
   logic                res_ready = 1'b1;
   logic [W-1:0]        res_sum;
   logic                res_cout;
   logic                err;
   logic                err_clr = 1'b0;
`ifdef NCL_ONEHOT_CHECK_EN
   logic                onehot_err;
`endif

   ncl_qadd_seq #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
      .clk        (clk),
      .init       (init),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_bin      (a_bin),
      .b_bin      (b_bin),
      .cin        (cin),
      .aq         (aq),
      .bq         (bq),
      .carryin    (carryin),
      .adder_init (adder_init),
      .ab_comp    (ab_comp),
      .sumq       (sumq),
      .carryout   (carryout),
      .sum_comp   (sum_comp),
      .carry_comp (carry_comp),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_sum    (res_sum),
      .res_cout   (res_cout),
`ifdef NCL_ONEHOT_CHECK_EN
      .onehot_err (onehot_err),
`endif
      .err        (err),
      .err_clr    (err_clr)
   );

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;
   int accept_cyc = 0;
   int multi_cyc  = -1;

   logic [W:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Behavioural array: 0 normal, 1 never returns carryout, 2 drives rails 1 and 2 of digit 2.
   int model_mode  = 0;
   int model_phase = 0;
   int model_cnt   = 0;
   int model_tot   = 0;

   function automatic int rail_val(input logic [3:0] r);
      rail_val = -1;
      for (int k = 0; k < 4; k++)
         if (r == (4'b0001 << k)) rail_val = k;
   endfunction

   function automatic bit inputs_data();
      inputs_data = (carryin == 2'b01) || (carryin == 2'b10);
      for (int i = 0; i < DIGITS; i++)
         if (rail_val(aq[4*i +: 4]) < 0 || rail_val(bq[4*i +: 4]) < 0) inputs_data = 0;
   endfunction

   always @(negedge clk) begin
      if (adder_init) begin
         ab_comp = '0;
         sumq = '0;
         carryout = '0;
         model_phase = 0;
      end else begin
         case (model_phase)
            0: if (inputs_data() && !sum_comp) begin
               model_tot = carryin[1] ? 1 : 0;
               for (int i = 0; i < DIGITS; i++)
                  model_tot += (rail_val(aq[4*i +: 4]) + rail_val(bq[4*i +: 4])) * (4 ** i);
               model_cnt = $urandom_range(1, 20);
               model_phase = 1;
            end
            1: begin
               model_cnt--;
               if (model_cnt == 0) begin
                  ab_comp = '1;
                  for (int i = 0; i < DIGITS; i++)
                     sumq[4*i +: 4] = 4'b0001 << ((model_tot / (4 ** i)) % 4);
                  if (model_mode == 1) carryout = 2'b00;
                  else carryout = (model_tot >= (1 << W)) ? 2'b10 : 2'b01;
                  if (model_mode == 2) begin
                     sumq[11:8] = 4'b0110;
                     multi_cyc = cyc;
                  end
                  model_phase = 2;
               end
            end
            2: if (aq == '0 && bq == '0 && carryin == 2'b00 && sum_comp) begin
               model_cnt = $urandom_range(1, 20);
               model_phase = 3;
            end
            default: begin
               model_cnt--;
               if (model_cnt == 0) begin
                  ab_comp = '0;
                  sumq = '0;
                  carryout = '0;
                  model_phase = 0;
               end
            end
         endcase
      end
   end

   // Monitor: scores each result when it first appears and watches it while held.
   logic         prev_rv = 1'b0;
   logic [W-1:0] hold_sum;
   logic         hold_cout;
   logic [W:0]   exp_v;

   always @(negedge clk) begin
      if (init) begin
         prev_rv = 1'b0;
      end else begin
         chk("carry_comp_follows", carry_comp, sum_comp);
         if (res_valid && !prev_rv) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("FAIL unexpected_result: got sum 0x%0h, expected no result", res_sum);
            end else begin
               exp_v = exp_q.pop_front();
               chk("res_sum", res_sum, exp_v[W-1:0]);
               chk("res_cout", res_cout, exp_v[W]);
            end
            chk("array_null_at_valid", {ab_comp, sumq, carryout}, 0);
            chk("sum_comp_low_at_valid", sum_comp, 0);
            hold_sum  = res_sum;
            hold_cout = res_cout;
         end else if (res_valid && prev_rv) begin
            chk("res_sum_stable", res_sum, hold_sum);
            chk("res_cout_stable", res_cout, hold_cout);
            chk("in_ready_low_in_result", in_ready, 0);
         end
         prev_rv = res_valid;
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit push);
      int t = 0;
      @(negedge clk);
      a_bin = a;
      b_bin = b;
      cin = c;
      in_valid = 1'b1;
      while (!in_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         chk("accept_timeout", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         accept_cyc = cyc + 1;
         if (push) exp_q.push_back({1'b0, a} + {1'b0, b} + {{W{1'b0}}, c});
         @(posedge clk);
         #1 in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      while ((exp_q.size() != 0 || res_valid || !in_ready) && t < 4000) begin
         @(negedge clk);
         t++;
      end
      chk("drain_idle", in_ready && exp_q.size() == 0, 1);
   endtask

   task automatic wait_err(output int ecyc);
      int t = 0;
      while (err !== 1'b1 && t < 2 * TIMEOUT_CYC) begin
         @(negedge clk);
         t++;
      end
      ecyc = cyc;
      chk("err_raised", err, 1);
   endtask

   task automatic clear_err();
      int t = 0;
      @(negedge clk);
      err_clr = 1'b1;
      while (err !== 1'b0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("err_cleared", err, 0);
      chk("ready_after_clear", in_ready, 1);
      err_clr = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_aq", aq, 0);
      chk("rst_bq", bq, 0);
      chk("rst_carryin", carryin, 0);
      chk("rst_sum_comp", sum_comp, 0);
      chk("rst_carry_comp", carry_comp, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_cout", res_cout, 0);
      chk("rst_err", err, 0);
      chk("rst_adder_init", adder_init, 1);
   endtask

   task automatic release_init();
      @(negedge clk);
      init = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("adder_init_held", adder_init, 1);
      chk("in_ready_held", in_ready, 0);
      @(negedge clk);
      chk("adder_init_released", adder_init, 0);
      chk("in_ready_released", in_ready, 1);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      n_fails++;
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ecyc;
      #1 init = 1'b1;
      @(negedge clk);
      #1 check_reset_outputs();
      release_init();

      send(8'h2D, 8'h1B, 1'b0, 1);
      send(8'hFF, 8'h01, 1'b0, 1);
      send(8'h00, 8'h00, 1'b1, 1);
      send(8'hFF, 8'hFF, 1'b1, 1);
      wait_idle();

      // Backpressure with a competing request held on in_valid.
      res_ready = 1'b0;
      send(8'hA5, 8'h3C, 1'b1, 1);
      begin
         int t = 0;
         while (!res_valid && t < 500) begin
            @(negedge clk);
            t++;
         end
      end
      a_bin = 8'h77;
      b_bin = 8'h11;
      cin = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("bp_in_ready_low", in_ready, 0);
         chk("bp_res_valid_high", res_valid, 1);
      end
      res_ready = 1'b1;
      send(8'h77, 8'h11, 1'b0, 1);
      wait_idle();

      for (int i = 0; i < 25; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(W'($urandom), W'($urandom), 1'($urandom), 1);
      end
      wait_idle();

      // Carryout never returns: timeout exactly TIMEOUT_CYC cycles after entering DATA_WAIT.
      model_mode = 1;
      send(8'h33, 8'h44, 1'b0, 0);
      wait_err(ecyc);
      chk("timeout_latency", ecyc - accept_cyc, TIMEOUT_CYC);
      chk("err_aq", aq, 0);
      chk("err_bq", bq, 0);
      chk("err_carryin", carryin, 0);
      chk("err_sum_comp", sum_comp, 1);
      chk("err_carry_comp", carry_comp, 1);
      chk("err_in_ready", in_ready, 0);
      chk("err_res_valid", res_valid, 0);
      model_mode = 0;
      clear_err();
      send(8'h01, 8'h02, 1'b0, 1);
      wait_idle();

      // Reset while the array is computing a DATA wavefront.
      send(8'h55, 8'h22, 1'b0, 0);
      @(negedge clk);
      @(negedge clk);
      init = 1'b1;
      #1 check_reset_outputs();
      release_init();
      send(8'h12, 8'h34, 1'b0, 1);
      wait_idle();

`ifdef NCL_ONEHOT_CHECK_EN
      model_mode = 2;
      send(8'h11, 8'h22, 1'b0, 0);
      wait_err(ecyc);
      chk("onehot_latency", ecyc - multi_cyc, SYNC_STAGES + 1);
      chk("onehot_err_set", onehot_err, 1);
      model_mode = 0;
      clear_err();
      chk("onehot_err_cleared", onehot_err, 0);
      send(8'h0F, 8'hF0, 1'b1, 1);
      wait_idle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
